de1_soc: RTL and testbench

DE1_SOC -- requirements
Module: de1_soc

---
 rtl/de1_soc_pkg.sv | 24 ++
 rtl/de1_soc_blocks.sv | 115 +++++++++++
 rtl/de1_soc.sv | 100 ++++++++++
 tb/tb_de1_soc.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/de1_soc_pkg.sv
// -----------------------------------------------------------------------------
// de1_soc_pkg
// Shared constants and types for the tug-of-war game on the DE1-SoC board.
//   NUM_LIGHTS  : number of playfield lights (LEDR[9:1])
//   CENTER_IDX  : LEDR index of the light that is lit after reset
//   BLANK/ONE/TWO : active-low seven-segment codes, bit order {g,f,e,d,c,b,a}
//   winner_e    : registered game result
// -----------------------------------------------------------------------------
package de1_soc_pkg;

    localparam int NUM_LIGHTS = 9;
    localparam int CENTER_IDX = 5;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] ONE   = 7'b1111001;
    localparam logic [6:0] TWO   = 7'b0100100;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } winner_e;

endpackage

// File: rtl/de1_soc_blocks.sv
// -----------------------------------------------------------------------------
// Building blocks for de1_soc. All resets are asynchronous and active-low.
//
// button  : 2-flop synchronizer followed by a rising-edge detector.
//   Clock   - system clock
//   Reset   - active-low asynchronous reset
//   pressed - raw, asynchronous "button is down" level
//   count   - registered one-cycle pulse per press
//
// light   : one playfield cell.
//   Clock, Reset - as above
//   L, R         - left-only / right-only move pulses (already game-gated)
//   NL, NR       - state of left / right neighbour (0 beyond the ends)
//   lightOn      - registered cell state; RESET_VAL is its reset value
//
// display : winner register and HEX0 decode.
//   Clock, Reset       - as above
//   L, R               - move pulses (already game-gated)
//   leftEnd, rightEnd  - state of LEDR[9] / LEDR[1]
//   hex                - registered active-low seven-segment output
//   winner             - registered game result (doubles as the game state)
// -----------------------------------------------------------------------------

module button (
    input  logic Clock,
    input  logic Reset,
    input  logic pressed,
    output logic count
);

    logic sync1;
    logic sync2;
    logic prev;

    // pressed is sampled by sync1 on the 1st edge, reaches sync2 on the 2nd
    // and the edge detect registers the pulse on the 3rd. The pulse is
    // registered so nothing downstream sees a combinational path from KEY.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            count <= 1'b0;
        end else begin
            sync1 <= pressed;
            sync2 <= sync1;
            prev  <= sync2;
            count <= sync2 & ~prev;
        end
    end

endmodule

module light #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic Clock,
    input  logic Reset,
    input  logic L,
    input  logic R,
    input  logic NL,
    input  logic NR,
    output logic lightOn
);

    logic next_on;

    // Left pulse pulls the light in from the right neighbour, right pulse from
    // the left neighbour; both or neither hold. At an end cell the missing
    // neighbour reads 0, so a winning move simply turns the last light off.
    always_comb begin
        next_on = (L & ~R & NR) | (R & ~L & NL) | (lightOn & ~(L ^ R));
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            lightOn <= RESET_VAL;
        end else begin
            lightOn <= next_on;
        end
    end

endmodule

module display
    import de1_soc_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       L,
    input  logic       R,
    input  logic       leftEnd,
    input  logic       rightEnd,
    output logic [6:0] hex,
    output winner_e    winner
);

    // The winner is latched once; further pulses are ignored here and are
    // also gated off upstream, so the display freezes until reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            winner <= NONE;
            hex    <= BLANK;
        end else if (winner == NONE) begin
            if (L && !R && leftEnd) begin
                winner <= LEFT;
                hex    <= TWO;
            end else if (R && !L && rightEnd) begin
                winner <= RIGHT;
                hex    <= ONE;
            end
        end
    end

endmodule

// File: rtl/de1_soc.sv
// -----------------------------------------------------------------------------
// de1_soc
// Two-player tug-of-war. KEY[3] (left player) and KEY[0] (right player) each
// move the single lit light one position toward their side; pushing the light
// off the end wins. The result appears on HEX0 ("2" left, "1" right) and the
// game freezes until reset.
//
// Ports:
//   CLOCK_50 - system clock, all state on its rising edge
//   KEY[3:0] - active-low pushbuttons (KEY[2:1] unused)
//   SW[9]    - asynchronous active-low reset; SW[8:0] unused
//   LEDR[9:0]- playfield on LEDR[9:1] (LEDR[9] leftmost), LEDR[0] held 0
//   HEX0[6:0]- active-low winner display {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module de1_soc
    import de1_soc_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0
);

    logic    reset_n;
    logic    left_raw;
    logic    right_raw;
    logic    left_pulse;
    logic    right_pulse;
    logic    game_over;
    winner_e winner;

    // field[0] and field[NUM_LIGHTS+1] are the missing neighbours at the ends.
    logic [NUM_LIGHTS+1:0] field;

    logic unused_inputs;
    assign unused_inputs = ^{SW[8:0], KEY[2:1]};

    assign reset_n = SW[9];

    button left_button (
        .Clock   (CLOCK_50),
        .Reset   (reset_n),
        .pressed (~KEY[3]),
        .count   (left_raw)
    );

    button right_button (
        .Clock   (CLOCK_50),
        .Reset   (reset_n),
        .pressed (~KEY[0]),
        .count   (right_raw)
    );

    // Once a winner is registered no pulse reaches the lights or the display.
    assign game_over   = (winner != NONE);
    assign left_pulse  = left_raw  & ~game_over;
    assign right_pulse = right_raw & ~game_over;

    assign field[0]            = 1'b0;
    assign field[NUM_LIGHTS+1] = 1'b0;

    for (genvar i = 1; i <= NUM_LIGHTS; i++) begin : g_cell
        if (i == CENTER_IDX) begin : g_center
            light #(.RESET_VAL(1'b1)) centerLight (
                .Clock   (CLOCK_50),
                .Reset   (reset_n),
                .L       (left_pulse),
                .R       (right_pulse),
                .NL      (field[i+1]),
                .NR      (field[i-1]),
                .lightOn (field[i])
            );
        end else begin : g_side
            light #(.RESET_VAL(1'b0)) side_light (
                .Clock   (CLOCK_50),
                .Reset   (reset_n),
                .L       (left_pulse),
                .R       (right_pulse),
                .NL      (field[i+1]),
                .NR      (field[i-1]),
                .lightOn (field[i])
            );
        end
    end

    display winner_display (
        .Clock    (CLOCK_50),
        .Reset    (reset_n),
        .L        (left_pulse),
        .R        (right_pulse),
        .leftEnd  (field[NUM_LIGHTS]),
        .rightEnd (field[1]),
        .hex      (HEX0),
        .winner   (winner)
    );

    assign LEDR = {field[NUM_LIGHTS:1], 1'b0};

endmodule

// File: tb/tb_de1_soc.sv
// -----------------------------------------------------------------------------
// tb_de1_soc
// Directed bench for de1_soc. Each driver step pushes the expected
// {LEDR, HEX0} onto exp_q and raises sample_valid for one cycle; the monitor
// pops and compares on the following falling edge.
// -----------------------------------------------------------------------------
module tb_de1_soc;
    import de1_soc_pkg::*;

    // ---------------- clock / reset ----------------
    logic       CLOCK_50 = 1'b0;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [6:0] HEX0;

    always #10 CLOCK_50 = ~CLOCK_50;

    de1_soc dut (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .SW       (SW),
        .LEDR     (LEDR),
        .HEX0     (HEX0)
    );

    // ---------------- scoreboard state ----------------
    logic [16:0] exp_q[$];
    string       name_q[$];
    logic        sample_valid = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // Called just after a rising edge; the monitor samples on the next falling
    // edge, before any further rising edge.
    task automatic expect_out(input string name, input logic [9:0] led, input logic [6:0] hex);
        exp_q.push_back({led, hex});
        name_q.push_back(name);
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
    endtask

    task automatic press(input logic right, input logic left, input int hold);
        KEY[0] = ~right;
        KEY[3] = ~left;
        tick(hold);
        KEY[0] = 1'b1;
        KEY[3] = 1'b1;
        tick(8);
    endtask

    task automatic do_reset;
        SW[9] = 1'b0;
        tick(2);
        SW[9] = 1'b1;
        tick(1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge CLOCK_50) begin
        if (sample_valid) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor: sample requested with empty expected queue");
            end else begin
                logic [16:0] exp_v;
                string       nm;
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                checks++;
                if ({LEDR, HEX0} !== exp_v) begin
                    errors++;
                    $display("FAIL %s: got LEDR=%h HEX0=%b, expected LEDR=%h HEX0=%b",
                             nm, LEDR, HEX0, exp_v[16:7], exp_v[6:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] centre;
        centre = 10'h020;
        KEY    = 4'hF;
        SW     = {1'b0, 9'($urandom_range(0, 511))};
        tick(3);
        expect_out("reset_held", 10'h020, BLANK);
        SW[9] = 1'b1;
        tick(2);
        expect_out("reset_release", 10'h020, BLANK);

        // Held key: one move only.
        press(1'b1, 1'b0, 20);
        expect_out("held_right", 10'h010, BLANK);

        // Right win.
        do_reset;
        expect_out("reset_before_right", 10'h020, BLANK);
        for (int i = 1; i <= 4; i++) begin
            press(1'b1, 1'b0, $urandom_range(3, 6));
            expect_out("right_step", centre >> i, BLANK);
        end
        press(1'b1, 1'b0, 4);
        expect_out("right_win", 10'h000, ONE);
        press(1'b1, 1'b0, 4);
        expect_out("frozen_after_right_key0", 10'h000, ONE);
        press(1'b0, 1'b1, 4);
        expect_out("frozen_after_right_key3", 10'h000, ONE);

        // Left win.
        do_reset;
        expect_out("reset_after_win", 10'h020, BLANK);
        for (int i = 1; i <= 4; i++) begin
            press(1'b0, 1'b1, $urandom_range(3, 6));
            expect_out("left_step", centre << i, BLANK);
        end
        press(1'b0, 1'b1, 4);
        expect_out("left_win", 10'h000, TWO);
        press(1'b0, 1'b1, 4);
        expect_out("frozen_after_left_key3", 10'h000, TWO);
        press(1'b1, 1'b0, 4);
        expect_out("frozen_after_left_key0", 10'h000, TWO);

        // Simultaneous presses hold.
        do_reset;
        press(1'b1, 1'b1, 5);
        expect_out("both_at_centre", 10'h020, BLANK);
        press(1'b0, 1'b1, 4);
        expect_out("left_one", 10'h040, BLANK);
        press(1'b1, 1'b1, 4);
        expect_out("both_off_centre", 10'h040, BLANK);
        press(1'b1, 1'b0, 4);
        expect_out("right_back", 10'h020, BLANK);

        // Reset mid-game takes effect before any clock edge.
        do_reset;
        press(1'b1, 1'b0, 4);
        press(1'b1, 1'b0, 4);
        expect_out("two_right", 10'h008, BLANK);
        SW[9] = 1'b0;
        expect_out("reset_mid_game", 10'h020, BLANK);
        SW[9] = 1'b1;
        tick(1);
        press(1'b0, 1'b1, 4);
        expect_out("resume_after_reset", 10'h040, BLANK);

        tick(2);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
